// File: rtl/dcache_nway_controller.sv
// Miss/write-back/refill sequencer for an N-way set-associative data cache,
// plus a whole-cache flush walk that writes back (and optionally invalidates) every line.
module dcache_nway_controller #(
  parameter int WAYS           = 2,
  parameter int SETS           = 16,
  parameter int WORDS_PER_LINE = 4,
  localparam int WW = $clog2(WORDS_PER_LINE),
  localparam int AW = $clog2(WAYS),
  localparam int SW = $clog2(SETS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pipe_req_valid,
  input  logic            hit,
  input  logic            miss,
  input  logic [WAYS-1:0] way_valid,
  input  logic [WAYS-1:0] way_dirty,
  input  logic            flush_all_req,
  input  logic            flush_invalidate,
  input  logic            l2_req_fulfilled,
  output logic            pipe_req_fulfilled,
  output logic            l2_req_valid,
  output logic            l2_req_type,
  output logic [WW-1:0]   word_offset,
  output logic [AW-1:0]   victim_way,
  output logic            walk_mode,
  output logic [SW-1:0]   walk_set_index,
  output logic            clear_dirty,
  output logic            clear_valid,
  output logic            finish_new_line_install,
  output logic            flush_all_done,
  output logic [2:0]      dbg_state
);

  // l2_req_type encoding: LOAD = 0, STORE = 1.
  localparam logic LOAD  = 1'b0;
  localparam logic STORE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITEBACK  = 3'd1,
    ST_REFILL     = 3'd2,
    ST_WALK_CHECK = 3'd3,
    ST_WALK_WB    = 3'd4
  } state_e;

  state_e        r_state;
  logic [AW-1:0] r_rr;
  logic [WW-1:0] r_word_offset;
  logic [AW-1:0] r_victim_way;
  logic [SW-1:0] r_walk_set;
  logic          r_invalidate;
  logic          r_flush_blk;

  logic          w_found;
  logic [AW-1:0] w_free_way;
  logic [AW-1:0] w_victim;
  logic          w_victim_dirty;
  logic          w_line_dirty;
  logic          w_last_beat;
  logic          w_last_line;
  logic          w_flush_start;
  logic          w_advance;
  logic [AW-1:0] w_adv_way;
  logic [SW-1:0] w_adv_set;

  logic w_fulfilled, w_l2_valid, w_l2_type, w_walk_mode;
  logic w_clear_dirty, w_clear_valid, w_install, w_done;

  // Lowest-index invalid way wins; the descending scan leaves the smallest index last.
  always_comb begin
    w_found    = 1'b0;
    w_free_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!way_valid[i]) begin
        w_found    = 1'b1;
        w_free_way = AW'(i);
      end
    end
  end

  assign w_victim       = w_found ? w_free_way : r_rr;
  assign w_victim_dirty = way_valid[w_victim] & way_dirty[w_victim];
  assign w_line_dirty   = way_valid[r_victim_way] & way_dirty[r_victim_way];
  assign w_last_beat    = l2_req_fulfilled && (r_word_offset == WW'(WORDS_PER_LINE - 1));
  assign w_last_line    = (r_walk_set == SW'(SETS - 1)) && (r_victim_way == AW'(WAYS - 1));
  // A finished walk must not restart until the requester drops flush_all_req.
  assign w_flush_start  = flush_all_req && !r_flush_blk;
  assign w_advance      = ((r_state == ST_WALK_CHECK) && !w_line_dirty) ||
                          ((r_state == ST_WALK_WB) && w_last_beat);
  assign w_adv_way      = r_victim_way + AW'(1);
  assign w_adv_set      = (r_victim_way == AW'(WAYS - 1)) ? r_walk_set + SW'(1) : r_walk_set;

  always_comb begin
    w_fulfilled   = 1'b0;
    w_l2_valid    = 1'b0;
    w_l2_type     = LOAD;
    w_walk_mode   = 1'b0;
    w_clear_dirty = 1'b0;
    w_clear_valid = 1'b0;
    w_install     = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_fulfilled = !w_flush_start && pipe_req_valid && hit;
      end
      ST_WRITEBACK: begin
        w_l2_valid    = 1'b1;
        w_l2_type     = STORE;
        w_clear_dirty = w_last_beat;
        w_clear_valid = w_last_beat;
      end
      ST_REFILL: begin
        w_l2_valid    = 1'b1;
        w_clear_dirty = w_last_beat;
        w_install     = w_last_beat;
      end
      ST_WALK_CHECK: begin
        w_walk_mode   = 1'b1;
        w_clear_valid = !w_line_dirty && r_invalidate;
        w_done        = !w_line_dirty && w_last_line;
      end
      ST_WALK_WB: begin
        w_walk_mode   = 1'b1;
        w_l2_valid    = 1'b1;
        w_l2_type     = STORE;
        w_clear_dirty = w_last_beat;
        w_clear_valid = w_last_beat && r_invalidate;
        w_done        = w_last_beat && w_last_line;
      end
      default: begin
        w_fulfilled   = 1'bx;
        w_l2_valid    = 1'bx;
        w_l2_type     = 1'bx;
        w_walk_mode   = 1'bx;
        w_clear_dirty = 1'bx;
        w_clear_valid = 1'bx;
        w_install     = 1'bx;
        w_done        = 1'bx;
      end
    endcase
    if (reset) begin
      w_fulfilled   = 1'b0;
      w_l2_valid    = 1'b0;
      w_l2_type     = LOAD;
      w_walk_mode   = 1'b0;
      w_clear_dirty = 1'b0;
      w_clear_valid = 1'b0;
      w_install     = 1'b0;
      w_done        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_rr          <= '0;
      r_word_offset <= '0;
      r_victim_way  <= '0;
      r_walk_set    <= '0;
      r_invalidate  <= 1'b0;
      r_flush_blk   <= 1'b0;
    end else begin
      if (!flush_all_req) r_flush_blk <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_flush_start) begin
            r_invalidate <= flush_invalidate;
            r_walk_set   <= '0;
            r_victim_way <= '0;
            r_state      <= ST_WALK_CHECK;
          end else if (pipe_req_valid && miss) begin
            r_victim_way  <= w_victim;
            r_word_offset <= '0;
            if (!w_found) r_rr <= r_rr + AW'(1);
            r_state <= w_victim_dirty ? ST_WRITEBACK : ST_REFILL;
          end
        end
        ST_WRITEBACK: begin
          if (l2_req_fulfilled) r_word_offset <= r_word_offset + WW'(1);
          if (w_last_beat) r_state <= ST_REFILL;
        end
        ST_REFILL: begin
          if (l2_req_fulfilled) r_word_offset <= r_word_offset + WW'(1);
          if (w_last_beat) r_state <= ST_IDLE;
        end
        ST_WALK_CHECK: begin
          if (w_line_dirty) begin
            r_word_offset <= '0;
            r_state       <= ST_WALK_WB;
          end
        end
        ST_WALK_WB: begin
          if (l2_req_fulfilled) r_word_offset <= r_word_offset + WW'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
      // Step to the next (set, way) of the walk; the final line ends it.
      if (w_advance) begin
        r_victim_way <= w_adv_way;
        r_walk_set   <= w_adv_set;
        if (w_last_line) begin
          r_state     <= ST_IDLE;
          r_flush_blk <= 1'b1;
        end else begin
          r_state <= ST_WALK_CHECK;
        end
      end
    end
  end

  assign pipe_req_fulfilled      = w_fulfilled;
  assign l2_req_valid            = w_l2_valid;
  assign l2_req_type             = w_l2_type;
  assign walk_mode               = w_walk_mode;
  assign clear_dirty             = w_clear_dirty;
  assign clear_valid             = w_clear_valid;
  assign finish_new_line_install = w_install;
  assign flush_all_done          = w_done;
  assign word_offset             = reset ? '0 : r_word_offset;
  assign victim_way              = reset ? '0 : r_victim_way;
  assign walk_set_index          = reset ? '0 : r_walk_set;
  assign dbg_state               = r_state;

endmodule

// File: tb/tb_dcache_nway_controller.sv
// Directed bench for dcache_nway_controller (WAYS=2, SETS=4, WORDS_PER_LINE=4):
// cycle-by-cycle vector table plus hand sequences for stall, reset abort and the flush walk.
module tb_dcache_nway_controller;

  logic       clk;
  logic       reset;
  logic       pipe_req_valid, hit, miss;
  logic [1:0] way_valid, way_dirty;
  logic       flush_all_req, flush_invalidate, l2_req_fulfilled;
  logic       pipe_req_fulfilled, l2_req_valid, l2_req_type;
  logic [1:0] word_offset;
  logic       victim_way;
  logic       walk_mode;
  logic [1:0] walk_set_index;
  logic       clear_dirty, clear_valid, finish_new_line_install, flush_all_done;
  logic [2:0] dbg_state;

  dcache_nway_controller #(.WAYS(2), .SETS(4), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .reset(reset),
    .pipe_req_valid(pipe_req_valid), .hit(hit), .miss(miss),
    .way_valid(way_valid), .way_dirty(way_dirty),
    .flush_all_req(flush_all_req), .flush_invalidate(flush_invalidate),
    .l2_req_fulfilled(l2_req_fulfilled),
    .pipe_req_fulfilled(pipe_req_fulfilled), .l2_req_valid(l2_req_valid),
    .l2_req_type(l2_req_type), .word_offset(word_offset), .victim_way(victim_way),
    .walk_mode(walk_mode), .walk_set_index(walk_set_index),
    .clear_dirty(clear_dirty), .clear_valid(clear_valid),
    .finish_new_line_install(finish_new_line_install), .flush_all_done(flush_all_done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, pv, h, m;
    logic [1:0]  wv, wd;
    logic        l2f;
    logic [12:0] exp;
  } vec_t;

  vec_t        vq[$];
  int          total = 0;
  int          bad = 0;
  logic [12:0] w_act;
  bit          mon_en = 1'b0;
  int          cv_cnt = 0, st_cnt = 0, st_set2 = 0, dn_cnt = 0;

  assign w_act = {pipe_req_fulfilled, l2_req_valid, l2_req_type, word_offset, victim_way,
                  walk_mode, walk_set_index, clear_dirty, clear_valid,
                  finish_new_line_install, flush_all_done};

  // Expected-output packing: fulfilled, l2v, type(1=STORE), offset, way, walk, set, cd, cv, install, done.
  function automatic logic [12:0] pk(input int f, l2v, l2t, wo, vw, wm, ws, cd, cv, ins, dn);
    return {f[0], l2v[0], l2t[0], wo[1:0], vw[0], wm[0], ws[1:0], cd[0], cv[0], ins[0], dn[0]};
  endfunction

  task automatic add(input int rst, pv, h, m, wv, wd, l2f, input logic [12:0] ex);
    vec_t r;
    r.rst = rst[0]; r.pv = pv[0]; r.h = h[0]; r.m = m[0];
    r.wv = wv[1:0]; r.wd = wd[1:0]; r.l2f = l2f[0]; r.exp = ex;
    vq.push_back(r);
  endtask

  // scoreboard
  task automatic check(input string nm, input logic [12:0] ex);
    total++;
    if (w_act !== ex) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, w_act, ex);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int ex);
    total++;
    if (act != ex) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, ex);
    end
  endtask

  // driver: inputs already set; check this cycle, then advance to just after the next edge
  task automatic cyc(input string nm, input logic [12:0] ex);
    #1;
    check(nm, ex);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (clear_valid) cv_cnt++;
      if (flush_all_done) dn_cnt++;
      if (l2_req_valid && l2_req_type && l2_req_fulfilled) begin
        st_cnt++;
        if (walk_set_index == 2'd2) st_set2++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [12:0] z;

  initial begin
    z = pk(0,0,0,0,0,0,0,0,0,0,0);
    reset = 1'b1; pipe_req_valid = 1'b0; hit = 1'b0; miss = 1'b0;
    way_valid = 2'b00; way_dirty = 2'b00;
    flush_all_req = 1'b0; flush_invalidate = 1'b0; l2_req_fulfilled = 1'b0;

    // Vector table: one record per cycle, outputs expected before the edge.
    add(1,1,1,0,3,3,0, z);                            // reset masks a hit
    add(1,0,0,0,0,0,0, z);
    add(0,1,1,0,3,3,0, pk(1,0,0,0,0,0,0,0,0,0,0));    // hit
    add(0,0,0,0,3,3,0, z);
    add(0,1,0,1,1,1,0, z);                            // clean miss, way1 invalid
    add(0,0,0,0,3,1,1, pk(0,1,0,0,1,0,0,0,0,0,0));
    add(0,0,0,0,3,1,0, pk(0,1,0,1,1,0,0,0,0,0,0));
    add(0,0,0,0,3,1,1, pk(0,1,0,1,1,0,0,0,0,0,0));
    add(0,0,0,0,3,1,1, pk(0,1,0,2,1,0,0,0,0,0,0));
    add(0,0,0,0,3,1,1, pk(0,1,0,3,1,0,0,1,0,1,0));
    add(0,1,1,0,3,3,0, pk(1,0,0,0,1,0,0,0,0,0,0));    // re-presented hit
    add(0,1,0,1,3,3,0, pk(0,0,0,0,1,0,0,0,0,0,0));    // dirty miss, rr=0
    for (int b = 0; b < 4; b++)
      add(0,0,0,0,3,3,1, pk(0,1,1,b,0,0,0,b==3,b==3,0,0));
    for (int b = 0; b < 4; b++)
      add(0,0,0,0,3,3,1, pk(0,1,0,b,0,0,0,b==3,0,b==3,0));
    add(0,1,0,1,3,0,0, pk(0,0,0,0,0,0,0,0,0,0,0));    // all valid, clean: rr now 1
    add(0,0,0,0,3,0,0, pk(0,1,0,0,1,0,0,0,0,0,0));
    for (int b = 0; b < 4; b++)
      add(0,0,0,0,3,0,1, pk(0,1,0,b,1,0,0,b==3,0,b==3,0));
    add(0,1,0,1,3,2,0, pk(0,0,0,0,1,0,0,0,0,0,0));    // rr wrapped to 0, way0 clean
    add(0,0,0,0,3,2,0, pk(0,1,0,0,0,0,0,0,0,0,0));
    add(1,0,0,0,3,2,1, z);                            // reset mid-refill
    add(0,0,0,0,3,2,0, z);

    @(posedge clk);
    #1;
    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; pipe_req_valid = vq[i].pv; hit = vq[i].h; miss = vq[i].m;
      way_valid = vq[i].wv; way_dirty = vq[i].wd; l2_req_fulfilled = vq[i].l2f;
      cyc($sformatf("vec%0d", i), vq[i].exp);
    end

    // L2 stall mid-refill
    pipe_req_valid = 1'b1; miss = 1'b1; way_valid = 2'b01; way_dirty = 2'b00; l2_req_fulfilled = 1'b0;
    cyc("stall_miss", z);
    pipe_req_valid = 1'b0; miss = 1'b0; l2_req_fulfilled = 1'b1;
    cyc("stall_b0", pk(0,1,0,0,1,0,0,0,0,0,0));
    l2_req_fulfilled = 1'b0;
    for (int k = 0; k < 5; k++) cyc("stall_hold", pk(0,1,0,1,1,0,0,0,0,0,0));
    l2_req_fulfilled = 1'b1;
    for (int b = 1; b < 4; b++) cyc("stall_beat", pk(0,1,0,b,1,0,0,b==3,0,b==3,0));
    l2_req_fulfilled = 1'b0;
    check_int("stall_idle_state", int'(dbg_state), 0);

    // Reset at beat 2 of a write-back
    pipe_req_valid = 1'b1; miss = 1'b1; way_valid = 2'b11; way_dirty = 2'b11;
    cyc("wbrst_miss", pk(0,0,0,0,1,0,0,0,0,0,0));
    pipe_req_valid = 1'b0; miss = 1'b0; l2_req_fulfilled = 1'b1;
    for (int b = 0; b < 2; b++) cyc("wbrst_beat", pk(0,1,1,b,0,0,0,0,0,0,0));
    reset = 1'b1;
    cyc("wbrst_in_reset", z);
    reset = 1'b0; l2_req_fulfilled = 1'b0;
    check_int("wbrst_state", int'(dbg_state), 0);
    cyc("wbrst_after", z);

    // Flush walk with invalidate: only set 2 way 1 dirty
    mon_en = 1'b1;
    flush_all_req = 1'b1; flush_invalidate = 1'b1; pipe_req_valid = 1'b1; hit = 1'b1;
    cyc("flush_prio", z);
    pipe_req_valid = 1'b0; hit = 1'b0; flush_invalidate = 1'b0;
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 2; w++) begin
        way_valid = 2'b11;
        way_dirty = (s == 2) ? 2'b10 : 2'b00;
        l2_req_fulfilled = 1'b0;
        if (s == 2 && w == 1) begin
          cyc("walk_chk_dirty", pk(0,0,0,0,w,1,s,0,0,0,0));
          l2_req_fulfilled = 1'b1;
          for (int b = 0; b < 4; b++) cyc("walk_wb", pk(0,1,1,b,w,1,s,b==3,b==3,0,0));
        end else begin
          cyc("walk_chk", pk(0,0,0,0,w,1,s,0,1,0,(s==3 && w==1)));
        end
      end
    end
    l2_req_fulfilled = 1'b0; way_dirty = 2'b00;
    cyc("post_done_held", z);
    mon_en = 1'b0;
    check_int("no_reentry_state", int'(dbg_state), 0);
    flush_all_req = 1'b0;
    cyc("flush_released", z);
    check_int("walk_clear_valid_cnt", cv_cnt, 8);
    check_int("walk_store_beats", st_cnt, 4);
    check_int("walk_store_set2", st_set2, 4);
    check_int("walk_done_cnt", dn_cnt, 1);

    // Flush without invalidate, aborted by reset
    flush_all_req = 1'b1; flush_invalidate = 1'b0;
    cyc("flush2_start", z);
    cyc("flush2_noinv", pk(0,0,0,0,0,1,0,0,0,0,0));
    reset = 1'b1;
    cyc("flush2_reset", z);
    reset = 1'b0; flush_all_req = 1'b0;
    cyc("flush2_after", z);
    check_int("flush2_state", int'(dbg_state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_nway_controller.md
DCACHE_NWAY_CONTROLLER -- requirements
Module: dcache_nway_controller

Interface
REQ-001 Parameter WAYS, default 2, meaning associativity; power of two, at least 2.
REQ-002 Parameter SETS, default 16, meaning sets per way; power of two, at least 2.
REQ-003 Parameter WORDS_PER_LINE, default 4, meaning L2 beats per line; power of two, at least 2; WW=$clog2(WORDS_PER_LINE), AW=$clog2(WAYS), SW=$clog2(SETS).
REQ-004 clk  in  1  clock; one clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pipe_req_valid  in  1  pipeline access pending; hit, miss and way_* are valid for the addressed set.
REQ-007 hit, miss  in  1 each  tag compare result for the current pipe request; never both high.
REQ-008 way_valid, way_dirty  in  WAYS each  per-way valid and dirty bits of the set currently addressed, pipe or walk.
REQ-009 flush_all_req  in  1  request a write-back walk of the whole cache; level, held until flush_all_done.
REQ-010 flush_invalidate  in  1  sampled with flush_all_req; 1 = also invalidate every line during the walk.
REQ-011 l2_req_fulfilled  in  1  L2 accepted or returned the current beat.
REQ-012 pipe_req_fulfilled  out  1  Mealy; request completed this cycle.
REQ-013 l2_req_valid  out  1; l2_req_type  out  memory_operation_e  LOAD or STORE.
REQ-014 word_offset  out  WW  beat index of the current L2 transfer.
REQ-015 victim_way  out  AW  registered way being evicted, refilled or walked.
REQ-016 walk_mode  out  1; walk_set_index  out  SW  set addressed during the walk.
REQ-017 clear_dirty, clear_valid, finish_new_line_install, flush_all_done  out  1 each  single-cycle pulses.

Function
REQ-018 States: ST_IDLE, ST_WRITEBACK, ST_REFILL, ST_WALK_CHECK, ST_WALK_WB.
REQ-019 ST_IDLE, flush_all_req=1: flush_invalidate is latched, walk_set_index=0, victim_way=0, go ST_WALK_CHECK; flush_all_req has priority over pipe_req_valid and pipe_req_fulfilled stays 0.
REQ-020 ST_IDLE, pipe_req_valid and hit: pipe_req_fulfilled=1 the same cycle; stay in ST_IDLE.
REQ-021 ST_IDLE, pipe_req_valid and miss: the victim is the lowest-index way with way_valid=0; if every way is valid, the victim is the round-robin pointer rr.
REQ-022 On a miss the victim is registered into victim_way and word_offset is cleared to 0.
REQ-023 After a miss, go ST_WRITEBACK if the victim is valid and dirty, else go ST_REFILL.
REQ-024 ST_WRITEBACK and ST_WALK_WB: l2_req_valid=1 and l2_req_type=STORE.
REQ-025 ST_REFILL: l2_req_valid=1 and l2_req_type=LOAD.
REQ-026 In every other state l2_req_valid=0 and l2_req_type=LOAD.
REQ-027 word_offset increments by 1 on each l2_req_fulfilled in a transfer state; the last beat is word_offset=WORDS_PER_LINE-1 with l2_req_fulfilled.
REQ-028 Last beat in ST_WRITEBACK: pulse clear_dirty and clear_valid, wrap word_offset to 0, go ST_REFILL.
REQ-029 Last beat in ST_REFILL: pulse finish_new_line_install and clear_dirty, go ST_IDLE.
REQ-030 rr advances modulo WAYS only when the victim came from rr; the pipeline re-presents the request, which then hits.
REQ-031 ST_WALK_CHECK: walk_mode=1; if way_valid[victim_way]&way_dirty[victim_way], go ST_WALK_WB with word_offset=0.
REQ-032 ST_WALK_CHECK, line not dirty: pulse clear_valid if latched invalidate, then advance.
REQ-033 Last beat in ST_WALK_WB: pulse clear_dirty, plus clear_valid if latched invalidate, then advance.
REQ-034 Advance: victim_way increments; on wrap from WAYS-1 it returns to 0 and walk_set_index increments.
REQ-035 Advancing from set SETS-1, way WAYS-1: pulse flush_all_done, go ST_IDLE; do not re-enter the walk while flush_all_req is still high that cycle.
REQ-036 No L2 beat without l2_req_fulfilled advances state; the controller waits indefinitely.
REQ-037 Parameter arithmetic uses unsigned widths with natural modulo wrap.
REQ-038 Illegal state encodings drive all outputs to X.

Reset
REQ-039 On reset: state=ST_IDLE; rr=0; word_offset=0; victim_way=0; walk_set_index=0; latched invalidate=0.
REQ-040 During reset every output is 0 and l2_req_type=LOAD.
REQ-041 Reset mid-transfer or mid-walk aborts it at the next edge with no done or install pulse; l2_req_valid is 0 the following cycle.

Verification (WAYS=2, SETS=4, WORDS_PER_LINE=4)
REQ-042 Hit: pipe_req_valid=1, hit=1 -> pipe_req_fulfilled=1 same cycle, l2_req_valid stays 0.
REQ-043 Clean miss: way_valid=2'b01, miss=1 -> victim_way=1, 4 LOAD beats, finish_new_line_install on the 4th fulfilled beat, rr unchanged.
REQ-044 Dirty miss: way_valid=2'b11, way_dirty=2'b11, rr=0 -> 4 STORE beats, clear_dirty+clear_valid pulse, 4 LOAD beats, rr=1 after install.
REQ-045 L2 stall: l2_req_fulfilled low for 5 cycles mid-refill -> word_offset holds, l2_req_valid stays 1.
REQ-046 Walk: only set 2 way 1 dirty, flush_invalidate=1 -> exactly 4 STORE beats at walk_set_index=2; clear_valid pulsed for all 8 lines; flush_all_done once.
REQ-047 Reset asserted at beat 2 of a write-back -> ST_IDLE; no pulses; l2_req_valid=0 the cycle after.
